imm_chunker: RTL and testbench
==============================

# imm_chunker

Encoder counterpart to the datapath's 15-bit immediate sign extender. It accepts a 32-bit constant and emits the minimal sequence of 15-bit immediate chunks. The sequence reconstructs the constant exactly: sign-extend the first chunk, then for each later chunk compute acc = (acc << 15) | zero-extend(chunk). It sits between the constant/instruction builder and the instruction-stream writer, using valid/ready on both sides.

## Interface
- DATA_W, 32, width of the input constant
- IMM_W, 15, width of one immediate chunk
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  DATA_W  constant to encode, two's complement
- out_valid  output  1  out_chunk is valid
- out_ready  input  1  downstream accepts out_chunk this cycle
- out_chunk  output  IMM_W  current immediate chunk
- out_first  output  1  chunk is the first of its sequence (to be sign-extended)
- out_last  output  1  chunk is the last of its sequence
- out_count  output  2  total chunks in the current sequence (1..NCHUNK)

## Operation
- NCHUNK = ceil(DATA_W/IMM_W), which is 3 at the defaults.
- Chunk count k is the smallest k < NCHUNK for which in_data fits in signed k*IMM_W bits; otherwise k = NCHUNK.
  - k=1: range −16384..16383.
  - k=2: range −2^29..2^29−1.
- Chunk i (0-based, emitted in order) = in_data[(k−1−i)*IMM_W +: IMM_W].
  - For i=0 with k=NCHUNK, the chunk is the remaining top bits [31:30], sign-extended to IMM_W.
- FSM states:
  - IDLE → EMIT on in_valid && in_ready. Latch in_data and k; set chunk index 0.
  - EMIT: on out_valid && out_ready, advance the index if not last.
  - On the last chunk's handshake: if in_valid is high, accept the new word (stay in EMIT, index 0); otherwise go to IDLE.
- in_ready = rst_n && (state==IDLE || (state==EMIT && out_last && out_ready)). This gives zero-bubble back-to-back streaming.
- Output stability: while out_valid && !out_ready, out_chunk, out_first, out_last and out_count hold stable.
- out_first = (index==0); out_last = (index==k−1). With k=1, both are high.
- No data-dependent errors. Every DATA_W value is encodable.

## Timing
- All outputs are registered except in_ready, which is combinational from state, out_last and out_ready.
- Latency: the first chunk is valid on the cycle after the input handshake. A k-chunk word occupies k output cycles when out_ready is held high.
- Throughput: one chunk per cycle. There is no idle cycle between words when in_valid is high at the last-chunk handshake.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - out_valid = 0; out_chunk, out_first, out_last and out_count = 0.
  - in_ready = 0 while held in reset.
- Reset asserted mid-sequence abandons the sequence immediately. No partial chunk appears after reset deasserts. The first cycle after deassert has in_ready = 1.
- in_valid asserted while in_ready=0: the input is not consumed. The sender must hold in_data stable.

## Structure
- Package imm_pkg holds:
  - DATA_W, IMM_W and NCHUNK constants.
  - The state enum (IDLE, EMIT).
  - The chunk-index type, logic [1:0].
- Sub-module imm_fit_check: combinational. Takes in_data and returns k by comparing the upper bits against the sign bit of each candidate width. Instantiated once on the input path so that k is registered with the data.
- The top level holds the FSM, the data/k/index registers and the chunk-select mux.

## Test plan
- 0x00000005 → one chunk 0x0005, first=last=1, count=1. Also 0xFFFFC000 → one chunk 0x4000.
- 0xFFFFBFFF (−16385) → two chunks: 0x7FFF (first), then 0x3FFF (last); count=2. 0x12345678 → 0x2468, then 0x5678.
- 0x80000000 → three chunks: 0x7FFE, 0x0000, 0x0000; count=3. A model re-applying the sign-extend/shift/OR must return 0x80000000. Also run random constants through the same reconstruction check.
- Backpressure: 0x80000000 with out_ready low for 3 cycles on chunk index 1 → 0x0000 held stable with first=0, last=0; in_ready stays 0.
- Back-to-back: in_valid high continuously with 0x00000005, then 0xFFFFBFFF → output cycles 0x0005, 0x7FFF, 0x3FFF with no gap. The second word is accepted on the same cycle as the handshake of the first word's last chunk.
- Reset mid-sequence: assert rst_n low during chunk 1 of 0x80000000 → out_valid drops at once. After deassert, 0x00000007 yields a single chunk 0x0007, with no remnant of the old word.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared constants, types and the chunk-select helper for the immediate chunker.
package imm_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 15;
  localparam int unsigned NCHUNK = (DATA_W + IMM_W - 1) / IMM_W;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned SH_W   = $clog2(DATA_W);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  typedef logic [1:0]       idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [IMM_W-1:0] chunk;
    logic             first;
    logic             last;
    cnt_t             count;
  } chunk_t;

  // Chunk idx of a k-chunk word; the arithmetic shift sign-extends the short top chunk.
  function automatic chunk_t make_chunk(input logic [DATA_W-1:0] d, input cnt_t k,
                                        input idx_t idx);
    logic [SH_W-1:0]   pos;
    logic [DATA_W-1:0] sh;
    chunk_t            c;
    pos     = SH_W'(k - idx - 2'd1) * SH_W'(IMM_W);
    sh      = $signed(d) >>> pos;
    c.chunk = sh[IMM_W-1:0];
    c.first = (idx == idx_t'(0));
    c.last  = (idx == idx_t'(k - 2'd1));
    c.count = k;
    return c;
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Smallest chunk count whose signed width holds the input constant.
module imm_fit_check
  import imm_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output cnt_t              k
);

  logic [DATA_W-1:0] upper;

  // Fits j chunks when every bit from the candidate sign position upward agrees.
  always_comb begin
    k     = cnt_t'(NCHUNK);
    upper = '0;
    for (int j = int'(NCHUNK) - 1; j >= 1; j--) begin
      upper = $signed(data) >>> (j * int'(IMM_W) - 1);
      if (upper == '0 || upper == '1) begin
        k = cnt_t'(j);
      end
    end
  end

endmodule

// File: rtl/imm_chunker.sv
// Splits a 32-bit constant into the minimal sequence of 15-bit immediate chunks.
module imm_chunker
  import imm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_chunk,
  output logic              out_first,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_count
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  cnt_t              k_q, k_d;
  idx_t              idx_q, idx_d;
  chunk_t            out_q, out_d;
  logic              valid_q, valid_d;
  cnt_t              fit_k;
  logic              accept;
  logic              fire;

  imm_fit_check u_fit (
    .data (in_data),
    .k    (fit_k)
  );

  // Accept in IDLE, or on the last chunk's handshake for zero-bubble streaming.
  always_comb begin
    in_ready = rst_n && ((state_q == IDLE) ||
                         ((state_q == EMIT) && out_q.last && out_ready));
  end

  assign accept = in_valid && in_ready;
  assign fire   = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    k_d     = k_q;
    idx_d   = idx_q;
    out_d   = out_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EMIT;
          data_d  = in_data;
          k_d     = fit_k;
          idx_d   = '0;
          valid_d = 1'b1;
          out_d   = make_chunk(in_data, fit_k, '0);
        end
      end
      EMIT: begin
        if (fire) begin
          if (out_q.last) begin
            if (accept) begin
              data_d  = in_data;
              k_d     = fit_k;
              idx_d   = '0;
              out_d   = make_chunk(in_data, fit_k, '0);
            end else begin
              state_d = IDLE;
              valid_d = 1'b0;
            end
          end else begin
            idx_d = idx_t'(idx_q + 2'd1);
            out_d = make_chunk(data_q, k_q, idx_t'(idx_q + 2'd1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      k_q     <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_chunk = out_q.chunk;
  assign out_first = out_q.first;
  assign out_last  = out_q.last;
  assign out_count = out_q.count;

endmodule

// File: tb/tb_imm_chunker.sv
// Directed and random checks of chunk sequences, handshakes and reset for imm_chunker.
module tb_imm_chunker;
  import imm_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [IMM_W-1:0]  out_chunk;
  logic              out_first;
  logic              out_last;
  logic [CNT_W-1:0]  out_count;

  int          total = 0;
  int          bad = 0;
  logic [31:0] acc = '0;

  imm_chunker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chunk (out_chunk),
    .out_first (out_first),
    .out_last  (out_last),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_k(input logic [31:0] d);
    int s;
    s = $signed(d);
    if (s >= -16384 && s <= 16383) return 1;
    if (s >= -(1 << 29) && s <= (1 << 29) - 1) return 2;
    return 3;
  endfunction

  // Present a word, wait (bounded) for in_ready, hand it over, then drop in_valid.
  task automatic send(input logic [31:0] d);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Check the chunk presented now, fold it into acc, then let one edge consume it.
  task automatic get_chunk(input string tag, input logic [14:0] c, input logic f,
                           input logic l, input int cnt);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_chunk"}, 32'(out_chunk), 32'(c));
    chk({tag, "_first"}, 32'(out_first), 32'(f));
    chk({tag, "_last"},  32'(out_last),  32'(l));
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
    if (out_first) acc = {{17{out_chunk[14]}}, out_chunk};
    else           acc = (acc << 15) | {17'b0, out_chunk};
    @(negedge clk);
  endtask

  task automatic run_random(input logic [31:0] d);
    int   n;
    int   cnt;
    logic done;
    send(d);
    n = 0; cnt = 0; done = 1'b0;
    while (!done && n < 8) begin
      if (out_valid) begin
        if (out_first) acc = {{17{out_chunk[14]}}, out_chunk};
        else           acc = (acc << 15) | {17'b0, out_chunk};
        cnt = int'(out_count);
        done = out_last;
      end
      @(negedge clk);
      n++;
    end
    chk("rand_done", 32'(done), 32'd1);
    chk("rand_count", 32'(cnt), 32'(exp_k(d)));
    chk("rand_recon", acc, d);
  endtask

  initial begin
    logic [31:0] r;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_chunk", 32'(out_chunk), 32'd0);
    chk("rst_flags", {29'b0, out_first, out_last, 1'b0}, 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Single-chunk words
    send(32'h0000_0005);
    get_chunk("w5", 15'h0005, 1'b1, 1'b1, 1);
    chk("w5_idle", 32'(out_valid), 32'd0);
    send(32'hFFFF_C000);
    get_chunk("wc000", 15'h4000, 1'b1, 1'b1, 1);
    chk("wc000_recon", acc, 32'hFFFF_C000);

    // Two-chunk words
    send(32'hFFFF_BFFF);
    get_chunk("wbfff0", 15'h7FFF, 1'b1, 1'b0, 2);
    get_chunk("wbfff1", 15'h3FFF, 1'b0, 1'b1, 2);
    chk("wbfff_recon", acc, 32'hFFFF_BFFF);
    send(32'h1234_5678);
    get_chunk("w1234_0", 15'h2468, 1'b1, 1'b0, 2);
    get_chunk("w1234_1", 15'h5678, 1'b0, 1'b1, 2);
    chk("w1234_recon", acc, 32'h1234_5678);

    // Three-chunk word
    send(32'h8000_0000);
    get_chunk("w8_0", 15'h7FFE, 1'b1, 1'b0, 3);
    get_chunk("w8_1", 15'h0000, 1'b0, 1'b0, 3);
    get_chunk("w8_2", 15'h0000, 1'b0, 1'b1, 3);
    chk("w8_recon", acc, 32'h8000_0000);

    // Backpressure on chunk index 1
    send(32'h8000_0000);
    get_chunk("bp_0", 15'h7FFE, 1'b1, 1'b0, 3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_chunk", 32'(out_chunk), 32'd0);
      chk("bp_hold_flags", {30'b0, out_first, out_last}, 32'd0);
      chk("bp_hold_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    get_chunk("bp_1", 15'h0000, 1'b0, 1'b0, 3);
    get_chunk("bp_2", 15'h0000, 1'b0, 1'b1, 3);
    chk("bp_idle", 32'(out_valid), 32'd0);

    // Back-to-back words with no gap
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_0005;
    chk("b2b_ready0", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_data = 32'hFFFF_BFFF;
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    get_chunk("b2b_a", 15'h0005, 1'b1, 1'b1, 1);
    in_valid = 1'b0;
    get_chunk("b2b_b0", 15'h7FFF, 1'b1, 1'b0, 2);
    get_chunk("b2b_b1", 15'h3FFF, 1'b0, 1'b1, 2);
    chk("b2b_idle", 32'(out_valid), 32'd0);

    // Reset mid-sequence
    send(32'h8000_0000);
    get_chunk("mr_0", 15'h7FFE, 1'b1, 1'b0, 3);
    chk("mr_1_chunk", 32'(out_chunk), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_post_ready", 32'(in_ready), 32'd1);
    chk("mr_post_valid", 32'(out_valid), 32'd0);
    send(32'h0000_0007);
    get_chunk("mr_new", 15'h0007, 1'b1, 1'b1, 1);
    chk("mr_idle", 32'(out_valid), 32'd0);

    // Random constants through the reconstruction model
    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      if (i % 3 == 0) r = $signed(r) >>> 17;
      else if (i % 3 == 1) r = $signed(r) >>> 2;
      run_random(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
